// File: rtl/uart_boot_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
// The loader is the master; the instruction memory is the slave.
interface uart_boot_loader_if;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_boot_loader.sv
// Receives a length-prefixed 8N1 byte stream, assembles little-endian words and
// writes them to instruction memory, holding the core idle until the image is in.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMEM_WORDS   = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_in,
  uart_boot_loader_if.master  imem,
  output logic                core_run,
  output logic                load_done,
  output logic                frame_err
);

  localparam int              CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]     MAX_WORDS = 16'(IMEM_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR} ld_state_t;

  rx_state_t     rx_state_q, rx_state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_valid_q, byte_valid_d;
  logic          byte_err_q, byte_err_d;
  logic          rx_s;

  ld_state_t     ld_state_q, ld_state_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   widx_q, widx_d;
  logic [1:0]    k_q, k_d;
  logic [31:0]   buf_q, buf_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   n_s;

  assign rx_s            = sync_q[1];
  assign n_s             = {shift_q, len_q[7:0]};
  assign imem.imem_we    = we_q;
  assign imem.imem_addr  = addr_q;
  assign imem.imem_wdata = wdata_q;
  assign core_run        = done_q;
  assign load_done       = done_q;
  assign frame_err       = err_q;

  // Receiver: mid-bit sampling timed from the first low sample of the start bit.
  always_comb begin
    sync_d       = {sync_q[0], rx_in};
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    byte_err_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) rx_state_d = RX_START;
        else       rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          bit_d = 3'd0;
          if (rx_s) rx_state_d = RX_IDLE;
          else      rx_state_d = RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               rx_state_d = RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          byte_valid_d = rx_s;
          byte_err_d   = ~rx_s;
          rx_state_d   = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receiver and synchronizer state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q       <= 2'b11;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      byte_err_q   <= byte_err_d;
    end
  end

  // Loader: length header, word assembly and the write strobe.
  always_comb begin
    ld_state_d = ld_state_q;
    len_d      = len_q;
    widx_d     = widx_q;
    k_d        = k_q;
    buf_d      = buf_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    case (ld_state_q)
      L_LEN0: begin
        if (byte_err_q) begin
          ld_state_d = L_ERR;
          err_d      = 1'b1;
        end else if (byte_valid_q) begin
          len_d[7:0] = shift_q;
          ld_state_d = L_LEN1;
        end else begin
          ld_state_d = L_LEN0;
        end
      end
      L_LEN1: begin
        if (byte_err_q) begin
          ld_state_d = L_ERR;
          err_d      = 1'b1;
        end else if (byte_valid_q) begin
          len_d = n_s;
          if (n_s == 16'd0) begin
            ld_state_d = L_DONE;
            done_d     = 1'b1;
          end else if (n_s > MAX_WORDS) begin
            ld_state_d = L_ERR;
            err_d      = 1'b1;
          end else begin
            ld_state_d = L_DATA;
            widx_d     = 16'd0;
            k_d        = 2'd0;
          end
        end else begin
          ld_state_d = L_LEN1;
        end
      end
      L_DATA: begin
        if (byte_err_q) begin
          ld_state_d = L_ERR;
          err_d      = 1'b1;
        end else if (byte_valid_q) begin
          buf_d[{k_q, 3'b000} +: 8] = shift_q;
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {14'd0, widx_q, 2'b00};
            wdata_d = {shift_q, buf_q[23:0]};
            widx_d  = widx_q + 16'd1;
            if (widx_q == len_q - 16'd1) ld_state_d = L_DONE;
            else                         ld_state_d = L_DATA;
          end else begin
            ld_state_d = L_DATA;
          end
        end else begin
          ld_state_d = L_DATA;
        end
      end
      L_DONE:  done_d     = 1'b1;
      L_ERR:   err_d      = 1'b1;
      default: ld_state_d = L_ERR;
    endcase
  end

  // Loader state and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ld_state_q <= L_LEN0;
      len_q      <= 16'd0;
      widx_q     <= 16'd0;
      k_q        <= 2'd0;
      buf_q      <= 32'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      len_q      <= len_d;
      widx_q     <= widx_d;
      k_q        <= k_d;
      buf_q      <= buf_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: table of load scenarios plus glitch and
// reset-mid-load sequences, with CLKS_PER_BIT = 4 and IMEM_WORDS = 4.
module tb_uart_boot_loader;
  localparam int CPB = 4;
  localparam int LAT_LO = 40;
  localparam int LAT_HI = 43;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx_in = 1'b1;
  logic core_run, load_done, frame_err;

  uart_boot_loader_if bus ();

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .IMEM_WORDS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (rx_in),
    .imem      (bus),
    .core_run  (core_run),
    .load_done (load_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nbytes;
    logic [95:0] bytes;    // byte i at [95-8*i -: 8]
    int          bad_idx;  // byte sent with a 0 stop bit, -1 for none
    int          ref_idx;  // byte whose arrival triggers done/error
    int          exp_nwr;
    logic [31:0] a0, d0, a1, d1;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [5];
  int          ntests = 0;
  int          nfail = 0;
  int          cyc = 0;
  int          start_cyc [16];
  int          nwr = 0;
  logic [31:0] wa [4];
  logic [31:0] wd [4];
  int          last_we_cyc = -1;
  int          done_cyc = -1;
  int          err_cyc = -1;
  int          we_long = 0;
  logic        prev_we = 1'b0;

  // Monitor samples 2 time units after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    cyc = cyc + 1;
    if (bus.imem_we === 1'b1) begin
      if (nwr < 4) begin
        wa[nwr] = bus.imem_addr;
        wd[nwr] = bus.imem_wdata;
      end
      nwr = nwr + 1;
      last_we_cyc = cyc;
      if (prev_we) we_long = we_long + 1;
    end
    prev_we = (bus.imem_we === 1'b1);
    if (load_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    if (frame_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    ntests++;
    if (act < lo || act > hi) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    rx_in = 1'b1;
    @(negedge clk);
    check("reset imem_we", {31'd0, bus.imem_we}, 32'd0);
    check("reset imem_addr", bus.imem_addr, 32'd0);
    check("reset imem_wdata", bus.imem_wdata, 32'd0);
    check("reset status", {29'd0, core_run, load_done, frame_err}, 32'd0);
    reset = 1'b1;
    nwr = 0;
    last_we_cyc = -1;
    done_cyc = -1;
    err_cyc = -1;
    we_long = 0;
    prev_we = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int idx);
    @(negedge clk);
    start_cyc[idx] = cyc;
    rx_in = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_in = b[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    rx_in = stop;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] b;
    do_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < v.nbytes; i++) begin
      b = v.bytes[95 - 8 * i -: 8];
      send_byte(b, (i != v.bad_idx), i);
      if (i == v.bad_idx) begin
        @(negedge clk);
        rx_in = 1'b1;
        repeat (8) @(negedge clk);
      end
    end
    repeat (60) @(negedge clk);
    check("write count", nwr, v.exp_nwr);
    check("we pulse width", we_long, 0);
    if (v.exp_nwr > 0) begin
      check("addr0", wa[0], v.a0);
      check("data0", wd[0], v.d0);
    end
    if (v.exp_nwr > 1) begin
      check("addr1", wa[1], v.a1);
      check("data1", wd[1], v.d1);
    end
    check("load_done", {31'd0, load_done}, {31'd0, v.exp_done});
    check("core_run", {31'd0, core_run}, {31'd0, v.exp_done});
    check("frame_err", {31'd0, frame_err}, {31'd0, v.exp_err});
    if (v.exp_done && v.exp_nwr > 0) begin
      check("done after last we", done_cyc - last_we_cyc, 1);
      check_rng("last we latency", last_we_cyc - start_cyc[v.ref_idx], LAT_LO, LAT_HI);
    end else if (v.exp_done) begin
      check_rng("done latency", done_cyc - start_cyc[v.ref_idx], LAT_LO, LAT_HI);
    end
    if (v.exp_err) begin
      check_rng("err latency", err_cyc - start_cyc[v.ref_idx], LAT_LO, LAT_HI);
    end
  endtask

  initial begin
    vecs[0] = '{10, 96'h020013001000930010000000, -1, 9, 2,
                32'h0, 32'h00100013, 32'h4, 32'h00100093, 1'b1, 1'b0};
    vecs[1] = '{4, 96'h0000AA550000000000000000, -1, 1, 0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{7, 96'h010013770011220000000000, 3, 3, 0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[3] = '{2, 96'h050000000000000000000000, -1, 1, 0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{2, 96'h000100000000000000000000, -1, 1, 0,
                32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Single-cycle low glitch while idle, then an empty image.
    do_reset();
    repeat (4) @(negedge clk);
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'h00, 1'b1, 0);
    send_byte(8'h00, 1'b1, 1);
    repeat (60) @(negedge clk);
    check("glitch writes", nwr, 0);
    check("glitch frame_err", {31'd0, frame_err}, 32'd0);
    check("glitch load_done", {31'd0, load_done}, 32'd1);
    check_rng("glitch done latency", done_cyc - start_cyc[1], LAT_LO, LAT_HI);

    // Partial load interrupted by reset, then the full nominal load.
    do_reset();
    repeat (4) @(negedge clk);
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'h13, 1'b1, 2);
    send_byte(8'h00, 1'b1, 3);
    check("partial writes", nwr, 0);
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Loads a program image into instruction memory over a UART serial line before the pipelined RISC-V core starts executing. Sits upstream of the core. It receives a length-prefixed byte stream, assembles little-endian 32-bit words, and issues one instruction-memory write per word at consecutive word addresses. It holds the core idle through `core_run` until the whole image is written.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `IMEM_WORDS`, default 256: instruction memory capacity in 32-bit words.

- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rx_in`  in  1  UART receive line, asynchronous, idle high.
- `imem_we`  out  1  instruction-memory write strobe, one-cycle pulse per word.
- `imem_addr`  out  32  byte address of the word being written; always a multiple of 4.
- `imem_wdata`  out  32  word being written.
- `core_run`  out  1  high once the load completes; drives the core's reset release.
- `load_done`  out  1  sticky, high once the load completes.
- `frame_err`  out  1  sticky, high on a framing or length error.

## Operation
- **Input synchronizer:** `rx_in` passes through a 2-FF synchronizer. All receive logic uses the synchronized value `rx_s`.
- **UART receiver:** 8N1 format, LSB first. States are RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE → RX_START when `rx_s` is 0.
  - RX_START waits CLKS_PER_BIT/2 cycles (integer division), then samples `rx_s`.
    - 1 → false start; return to RX_IDLE with no byte and no error.
    - 0 → enter RX_DATA.
  - RX_DATA samples `rx_s` every CLKS_PER_BIT cycles, 8 times, shifting bits into the byte LSB first.
  - RX_STOP samples once, CLKS_PER_BIT cycles after the last data bit.
    - 1 → raise an internal `byte_valid` for one cycle.
    - 0 → raise an internal `byte_err`.
    - Either way, return to RX_IDLE.
- **Loader FSM:** states are L_LEN0, L_LEN1, L_DATA, L_DONE, L_ERR.
  - L_LEN0: the first byte is bits [7:0] of the 16-bit word count N.
  - L_LEN1: the second byte is bits [15:8] of N. Then:
    - N == 0 → L_DONE.
    - N > IMEM_WORDS → L_ERR.
    - Otherwise → L_DATA, with word index 0 and byte index 0.
  - L_DATA: each byte is written to `imem_wdata` lane [8*k+7:8*k], where k is the 2-bit byte index. On k == 3, in the cycle after `byte_valid`:
    - `imem_we` = 1.
    - `imem_addr` = word_index × 4.
    - `imem_wdata` = the assembled word.
  - After each write, word index increments and k wraps to 0. The write of word N−1 moves the FSM to L_DONE in the same cycle that `imem_we` is asserted.
  - L_DONE: `core_run` = 1 and `load_done` = 1. Further bytes are ignored and framing errors are not flagged. This state is terminal until reset.
  - L_ERR: `frame_err` = 1 and `core_run` = 0. No further writes. This state is terminal until reset.
  - `byte_err` in any state other than L_DONE → L_ERR.
- **Arithmetic:**
  - word index is 16 bits wide; `imem_addr` = {14'b0, word_index, 2'b00}.
  - The N comparison is an unsigned 16-bit compare.
- **Partial words:** bytes belonging to a word that is never completed are never written.

## Timing
- Reset (`reset` == 0 on a rising edge):
  - Outputs: `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `core_run` 0, `load_done` 0, `frame_err` 0.
  - State: receiver in RX_IDLE, loader in L_LEN0, counters 0, synchronizer flops 1.
- Reset mid-byte or mid-word discards all partial state. The next load begins at address 0.
- Reception latency:
  - Falling edge on `rx_in` to `byte_valid`: 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles, ±1.
  - `imem_we` follows `byte_valid` by exactly 1 cycle.
- `imem_we` is high for exactly 1 cycle per word. `imem_addr` and `imem_wdata` are stable in that cycle and hold their values afterward.
- `core_run` and `load_done` rise in the cycle after the final write's `imem_we` pulse. For N == 0, they rise 1 cycle after the second length byte's `byte_valid`.
- `frame_err` rises 1 cycle after the offending `byte_err` or length check.
- Back-to-back bytes with no idle time between the stop bit and the next start bit are received correctly.

## Test plan
All scenarios use CLKS_PER_BIT = 4 and IMEM_WORDS = 4.

- **Nominal load:** send bytes 02 00 13 00 10 00 93 00 10 00.
  - Writes: (addr 0, 0x00100013) then (addr 4, 0x00100093), two `imem_we` pulses total.
  - `core_run` = `load_done` = 1 one cycle after the second write.
- **Empty image:** send 00 00.
  - No `imem_we`.
  - `load_done` = 1 one cycle after the second byte.
  - Later bytes AA 55 produce no writes.
- **Framing error:** send 01 00 13, then a byte whose stop bit is 0.
  - `frame_err` = 1.
  - No `imem_we`; `core_run` stays 0 through 3 further valid bytes.
- **Glitch rejection:** drive `rx_in` low for 1 cycle while idle, then send 00 00.
  - No error.
  - `load_done` = 1 exactly as in the empty-image case.
- **Length overflow:** send 05 00.
  - `frame_err` = 1, with no writes.
- **Reset mid-load:** send 02 00 13 00, assert `reset` low for 1 cycle, then replay the nominal load.
  - All outputs read 0 after reset.
  - Writes land at addr 0 and addr 4 with the nominal data.
